// File: rtl/zilla_mul_pkg.sv
// Shared definitions for the Zilla multiply path: widths, FSM encoding and
// the small Vedic cells that the 8x8 core is assembled from.
package zilla_mul_pkg;

    localparam int DATA_W = 32;
    localparam int CORE_W = 8;
    localparam int ITER   = (DATA_W / CORE_W) ** 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Urdhva-Tiryagbhyam 2x2: vertical products on the ends, crosswise sum in the middle.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic s1, c1;
        s1 = (a[1] & b[0]) ^ (a[0] & b[1]);
        c1 = (a[1] & b[0]) & (a[0] & b[1]);
        return {(a[1] & b[1]) & c1, (a[1] & b[1]) ^ c1, s1, a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        logic [4:0] mid;
        q0  = vedic_2x2(a[1:0], b[1:0]);
        q1  = vedic_2x2(a[3:2], b[1:0]);
        q2  = vedic_2x2(a[1:0], b[3:2]);
        q3  = vedic_2x2(a[3:2], b[3:2]);
        mid = {1'b0, q1} + {1'b0, q2};
        return {4'b0, q0} + {1'b0, mid, 2'b0} + {q3, 4'b0};
    endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 Vedic multiplier: four 4x4 cells whose crosswise
// products are summed and aligned around the two vertical products.
module vedic_8x8
    import zilla_mul_pkg::*;
(
    input  logic [CORE_W-1:0]   a,
    input  logic [CORE_W-1:0]   b,
    output logic [2*CORE_W-1:0] p
);

    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;

    assign q0  = vedic_4x4(a[3:0], b[3:0]);
    assign q1  = vedic_4x4(a[7:4], b[3:0]);
    assign q2  = vedic_4x4(a[3:0], b[7:4]);
    assign q3  = vedic_4x4(a[7:4], b[7:4]);
    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {8'b0, q0} + {3'b0, mid, 4'b0} + {q3, 8'b0};

endmodule

// File: rtl/vedic_mul32_seq.sv
// Iterative 32x32 multiplier: one byte pair per cycle through a shared 8x8
// Vedic core, shift-accumulated into 64 bits, sign fixed on the last pass.
module vedic_mul32_seq
    import zilla_mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]   b_in,
    input  logic                signed_in,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] result,
    output logic                busy
);

    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    state_t                state;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic                  neg;
    logic [2*DATA_W-1:0]   acc, acc_next, pp_shift;
    logic [3:0]            iter;
    logic [1:0]            ia, ib;
    logic [2:0]            pos;
    logic [CORE_W-1:0]     a_byte, b_byte;
    logic [2*CORE_W-1:0]   pp;

    // iter[1:0] walks the multiplicand bytes, iter[3:2] the multiplier bytes.
    assign ia       = iter[1:0];
    assign ib       = iter[3:2];
    assign a_byte   = a_mag[{ia, 3'b000} +: CORE_W];
    assign b_byte   = b_mag[{ib, 3'b000} +: CORE_W];
    assign pos      = {1'b0, ia} + {1'b0, ib};
    assign pp_shift = {48'b0, pp} << {pos, 3'b000};
    assign acc_next = acc + pp_shift;

    vedic_8x8 u_core (
        .a (a_byte),
        .b (b_byte),
        .p (pp)
    );

    // NOTE: all state, including the handshake flags, uses non-blocking assignment
    // so every register samples pre-edge values and the outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            acc       <= '0;
            iter      <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
                        a_mag    <= (signed_in && a_in[DATA_W-1]) ? -a_in : a_in;
                        b_mag    <= (signed_in && b_in[DATA_W-1]) ? -b_in : b_in;
                        neg      <= signed_in & (a_in[DATA_W-1] ^ b_in[DATA_W-1]);
                        acc      <= '0;
                        iter     <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        acc  <= acc_next;
                        iter <= iter + 4'd1;
                        if (iter == LAST_ITER) begin
                            result    <= neg ? (~acc_next + 64'd1) : acc_next;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vedic_mul32_seq.md
# vedic_mul32_seq

Iterative 32x32 multiplier that sits directly downstream of the Vedic small-multiplier cells. It accepts one operand pair through a valid/ready handshake and time-multiplexes a single combinational 8x8 Vedic core over 16 cycles, one byte pair per cycle. It shift-accumulates the partial products into a 64-bit product and returns the result through a second valid/ready handshake. Signed and unsigned operation are supported via sign-magnitude conversion, for use by the Zilla execute stage's multiply path.

## Interface
- DATA_W, 32: operand width; only 32 supported.
- CORE_W, 8: Vedic core width; ITER = (DATA_W/CORE_W)^2 = 16 iterations.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a_in  in  32  multiplicand.
- b_in  in  32  multiplier.
- signed_in  in  1  1 = both operands two's-complement, 0 = both unsigned.
- abort  in  1  synchronous cancel of the operation in flight.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- result  out  64  product.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch |a|, |b| (magnitudes if signed_in, else raw), neg = signed_in & (a[31]^b[31]), clear acc, iter=0, go to CALC.
- CALC, iteration i (0..15):
  - ia = i[1:0], ib = i[3:2].
  - pp = a_byte[ia] * b_byte[ib], computed by the 8x8 core (16-bit result).
  - acc += pp << (8*(ia+ib)).
  - All arithmetic is 64-bit unsigned. No overflow is possible.
- Last iteration (i=15):
  - result register ← neg ? (~acc_next + 1) : acc_next.
  - Go to DONE.
- DONE:
  - out_valid=1 and result stable.
  - On out_ready: go to IDLE, out_valid=0. result keeps its last value.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned, so no special case is needed.
- abort:
  - In CALC or DONE: go to IDLE next edge, out_valid=0, result unchanged. No output is produced.
  - In IDLE: ignored. abort has priority over in_valid on the same edge.
- in_valid while not IDLE is ignored; operands are not re-sampled.
- Reset (rst_n low at an edge, any state): IDLE, in_ready=1 after the edge, out_valid=0, busy=0, result=0, acc=0, iter=0.

## Timing
- Acceptance edge = cycle 0.
- CALC occupies cycles 1..16, one accumulate per edge.
- out_valid rises at cycle 17; latency is 17 cycles.
- The handshake completes on the edge where out_valid & out_ready. in_ready is high the following cycle.
- Minimum initiation interval is 18 cycles (17 + 1 IDLE cycle).
- No combinational paths from in_valid to in_ready or from out_ready to out_valid.
- The 8x8 core's critical path, plus the 64-bit add, must close at the execute-stage clock.

## Structure
- Shared package `zilla_mul_pkg`:
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
  - DATA_W, CORE_W, ITER constants
- One sub-module: `vedic_8x8`, a combinational 8x8 Vedic multiplier built from four 4x4 Vedic cells, each built from the team's 2x2 Vedic cell and adders.
- Top-level logic:
  - FSM
  - 4-bit iteration counter
  - byte-select muxes
  - barrel shift by 0/8/…/48
  - 64-bit accumulator
  - sign-fix negate

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, out_ready=1 → result 0xFFFFFFFE00000001; out_valid high exactly at cycle 17; in_ready high at cycle 18.
- Signed 0xFFFFFFFD × 0x00000007 → 0xFFFFFFFFFFFFFFEB (-21). The same operands with signed_in=0 → 0x00000006FFFFFFEB.
- Signed 0x80000000 × 0x80000000 → 0x4000000000000000. Unsigned 0x00010000 × 0x00010000 → 0x0000000100000000.
- Backpressure case:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands applied throughout.
  - Required: result held, in_ready=0, new operands ignored.
  - Then out_ready=1: accepted, and the next operation starts only from IDLE.
- rst_n=0 for one edge at CALC iteration 8 → next cycle in_ready=1, out_valid=0, busy=0, result=0. A fresh 3×5 then yields 15 at cycle 17.
- abort=1 at CALC iteration 4, with in_valid=1 on the same edge → IDLE, no out_valid ever asserted for that operation, new operands not accepted that edge.
